// File: rtl/fadder_bist_pkg.sv
// Shared types and helpers for the fadder BIST sequencer and its checker.
package fadder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // Expected {C,S} of a full adder for the vector {a,b,c}.
    function automatic logic [1:0] fa_expect(input logic [2:0] vec);
        return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
    endfunction

endpackage

// File: rtl/fadder_bist_check.sv
// Response comparator with saturating mismatch counter and first-failure capture.
module fadder_bist_check
    import fadder_bist_pkg::*;
#(
    parameter int ERR_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic [2:0]       vec_i,
    input  logic             s_i,
    input  logic             c_i,
    output logic [ERR_W-1:0] err_count_o,
    output logic             fail_valid_o,
    output logic [2:0]       fail_vec_o
);

    logic             mismatch;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;

    always_comb begin
        mismatch = sample_i && ({c_i, s_i} != fa_expect(vec_i));
        err_d    = err_q;
        fv_d     = fv_q;
        fvec_d   = fvec_q;
        if (clear_i) begin
            err_d  = '0;
            fv_d   = 1'b0;
            fvec_d = '0;
        end else if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            // Only the first mismatch of a run is recorded.
            if (!fv_q) begin
                fv_d   = 1'b1;
                fvec_d = vec_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q  <= '0;
            fv_q   <= 1'b0;
            fvec_q <= '0;
        end else begin
            err_q  <= err_d;
            fv_q   <= fv_d;
            fvec_q <= fvec_d;
        end
    end

    assign err_count_o  = err_q;
    assign fail_valid_o = fv_q;
    assign fail_vec_o   = fvec_q;

endmodule

// File: rtl/fadder_bist.sv
// BIST sequencer: sweeps all 3-bit vectors into a full adder and grades the response.
module fadder_bist
    import fadder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             s_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SWP_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SWP_W-1:0] SWEEP_LAST  = SWP_W'(PASSES - 1);

    state_e           state_q;
    logic [2:0]       vec_q;
    logic [SWP_W-1:0] sweep_q;
    logic [SET_W-1:0] settle_q;
    logic             busy_q, done_q, pass_q;
    logic             clear, sample;

    assign clear  = (state_q == IDLE) && start;
    assign sample = (state_q == CHECK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            sweep_q  <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    vec_q  <= '0;
                    busy_q <= 1'b0;
                    if (start) begin
                        pass_q   <= 1'b0;
                        sweep_q  <= '0;
                        settle_q <= SETTLE_LOAD;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                CHECK: begin
                    if (vec_q == VEC_LAST && sweep_q == SWEEP_LAST) begin
                        state_q <= DONE;
                    end else begin
                        vec_q    <= vec_q + 1'b1;
                        settle_q <= SETTLE_LOAD;
                        state_q  <= SETTLE;
                        if (vec_q == VEC_LAST) begin
                            sweep_q <= sweep_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (err_count == '0) && !fail_valid;
                    vec_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fadder_bist_check #(
        .ERR_W(ERR_W)
    ) u_check (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .sample_i    (sample),
        .vec_i       (vec_q),
        .s_i         (s_in),
        .c_i         (c_in),
        .err_count_o (err_count),
        .fail_valid_o(fail_valid),
        .fail_vec_o  (fail_vec)
    );

    assign {a, b, c} = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_fadder_bist.sv
// Bench for fadder_bist: two instances (default and PASSES=2/SETTLE=3/ERR_W=2) against a timeline model.
module tb_fadder_bist;

    localparam int S1 = 3;
    localparam int P1 = 2;
    localparam int W1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, rst_n1, start0, start1;
    logic       a0, b0, c0, s_r0, c_r0, busy0, done0, pass0, fv0;
    logic       a1, b1, c1, s_r1, c_r1, busy1, done1, pass1, fv1;
    logic [3:0] err0;
    logic [1:0] err1;
    logic [2:0] fvec0, fvec1;

    int mode [2];
    int total = 0;
    int bad   = 0;

    // Model state: k = cycles since accepted start (0 = never ran since reset).
    int k_m [2];
    int mode_run [2];
    int pass_m [2];
    int S_ [2];
    int P_ [2];
    int W_ [2];

    fadder_bist dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start0), .a(a0), .b(b0), .c(c0),
        .s_in(s_r0), .c_in(c_r0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
    );

    fadder_bist #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(W1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .a(a1), .b(b1), .c(c1),
        .s_in(s_r1), .c_in(c_r1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    // Adder response {C,S} under fault mode: 0 golden, 1 S stuck 0, 2 S/C swapped, 3 C stuck 1.
    function automatic int resp(int v, int m);
        int sum = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
        int s = sum & 1;
        int cy = sum >> 1;
        case (m)
            1:       return cy * 2;
            2:       return s * 2 + cy;
            3:       return 2 + s;
            default: return sum;
        endcase
    endfunction

    function automatic bit mism(int v, int m);
        return resp(v, m) != (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
    endfunction

    always_comb begin
        {c_r0, s_r0} = 2'(resp(int'({a0, b0, c0}), mode[0]));
        {c_r1, s_r1} = 2'(resp(int'({a1, b1, c1}), mode[1]));
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int run_len(int i);
        return 8 * P_[i] * (S_[i] + 1);
    endfunction

    task automatic cmp_inst(input int i, input int vec, input int bsy, input int dn,
                            input int ps, input int er, input int fv, input int fvec);
        int n = run_len(i);
        int k = k_m[i];
        int e_vec = 0, e_busy = 0, e_done = 0, errs = 0, e_fv = 0, e_fvec = 0, done_chk;
        if (k != 0) begin
            done_chk = (k - 1) / (S_[i] + 1);
            if (done_chk > 8 * P_[i]) done_chk = 8 * P_[i];
            for (int j = 0; j < done_chk; j++) begin
                if (mism(j % 8, mode_run[i])) begin
                    if (errs == 0) e_fvec = j % 8;
                    errs++;
                end
            end
            e_fv   = (errs != 0);
            e_busy = (k <= n + 1);
            e_done = (k == n + 2);
            if (k <= n)          e_vec = ((k - 1) / (S_[i] + 1)) % 8;
            else if (k == n + 1) e_vec = 7;
        end
        if (errs > (1 << W_[i]) - 1) errs = (1 << W_[i]) - 1;
        chk($sformatf("dut%0d.vec", i), vec, e_vec);
        chk($sformatf("dut%0d.busy", i), bsy, e_busy);
        chk($sformatf("dut%0d.done", i), dn, e_done);
        chk($sformatf("dut%0d.pass", i), ps, pass_m[i]);
        chk($sformatf("dut%0d.err_count", i), er, errs);
        chk($sformatf("dut%0d.fail_valid", i), fv, e_fv);
        if (e_fv != 0) chk($sformatf("dut%0d.fail_vec", i), fvec, e_fvec);
    endtask

    // Expected pass flag once a run of the latched mode completes.
    function automatic int run_passes(int i);
        for (int j = 0; j < 8; j++) if (mism(j, mode_run[i])) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic rn, st;
            int   n;
            rn = (i == 0) ? rst_n0 : rst_n1;
            st = (i == 0) ? start0 : start1;
            n  = run_len(i);
            if (!rn) begin
                k_m[i]    = 0;
                pass_m[i] = 0;
            end else if (k_m[i] == 0 || k_m[i] >= n + 2) begin
                if (st) begin
                    k_m[i]      = 1;
                    mode_run[i] = mode[i];
                    pass_m[i]   = 0;
                end else if (k_m[i] != 0 && k_m[i] < n + 3) begin
                    k_m[i]++;
                end
            end else begin
                k_m[i]++;
                if (k_m[i] == n + 2) pass_m[i] = run_passes(i);
            end
        end
        #2;
        cmp_inst(0, int'({a0, b0, c0}), int'(busy0), int'(done0), int'(pass0),
                 int'(err0), int'(fv0), int'(fvec0));
        cmp_inst(1, int'({a1, b1, c1}), int'(busy1), int'(done1), int'(pass1),
                 int'(err1), int'(fv1), int'(fvec1));
    end

    // Pulse start on one instance and count edges from the accept edge until done.
    task automatic run(input int i, input int m, input bit repulse, output int lat);
        mode[i] = m;
        @(negedge clk);
        if (i == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (i == 0) start0 = 1'b0; else start1 = 1'b0;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (repulse && (lat == 10 || lat == 30 + int'($urandom_range(0, 10)))) start1 = 1'b1;
            else if (i == 1) start1 = 1'b0;
            if ((i == 0) ? done0 : done1) break;
            if (lat > 500) begin
                chk($sformatf("dut%0d.done_timeout", i), lat, -1);
                break;
            end
        end
    endtask

    initial begin
        int lat;
        S_ = '{1, S1};
        P_ = '{1, P1};
        W_ = '{4, W1};
        k_m = '{0, 0};
        pass_m = '{0, 0};
        mode_run = '{0, 0};
        mode = '{0, 0};
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.vec", int'({a0, b0, c0}), 0);
        chk("reset.err_count", int'(err0), 0);
        @(negedge clk);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 0, 1'b0, lat);
        chk("golden.latency", lat, 17);
        chk("golden.pass", int'(pass0), 1);
        chk("golden.err_count", int'(err0), 0);

        run(0, 1, 1'b0, lat);
        chk("s_stuck0.err_count", int'(err0), 4);
        chk("s_stuck0.fail_vec", int'(fvec0), 1);
        chk("s_stuck0.pass", int'(pass0), 0);

        run(0, 2, 1'b0, lat);
        chk("swapped.err_count", int'(err0), 6);
        chk("swapped.fail_vec", int'(fvec0), 1);

        run(1, 3, 1'b1, lat);
        chk("c_stuck1.latency", lat, 65);
        chk("c_stuck1.err_count", int'(err1), 3);
        chk("c_stuck1.fail_vec", int'(fvec1), 0);
        chk("c_stuck1.fail_valid", int'(fv1), 1);

        run(1, 0, 1'b0, lat);
        chk("p2_golden.pass", int'(pass1), 1);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run(0, int'($urandom_range(0, 3)), 1'b0, lat);
        end

        // Abort in the middle of vector 5.
        mode[0] = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if ({a0, b0, c0} == 3'd5) break;
        end
        chk("abort.reached_vec5", int'({a0, b0, c0}), 5);
        repeat ($urandom_range(0, 1)) @(posedge clk);
        #1;
        rst_n0 = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.vec", int'({a0, b0, c0}), 0);
        chk("abort.busy", int'(busy0), 0);
        chk("abort.done", int'(done0), 0);
        @(negedge clk);
        rst_n0 = 1'b1;
        repeat (3) @(negedge clk);
        run(0, 0, 1'b0, lat);
        chk("after_abort.latency", lat, 17);
        chk("after_abort.pass", int'(pass0), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
